inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 107 ++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the ROM address from the PC, registers one
// instruction for decode, and tracks run/drain/halt around the end-program word.
module inst_fetch #(
  parameter int A = 16,
  parameter int W = 9,
  parameter logic [W-1:0] HALT_WORD = {W{1'b1}}
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [A-1:0] StartAddr,
  output logic [A-1:0] InstAddress,
  input  logic [W-1:0] InstIn,
  input  logic         BranchEn,
  input  logic [A-1:0] BranchTarget,
  output logic [W-1:0] InstOut,
  output logic [A-1:0] InstPC,
  output logic         InstValid,
  input  logic         InstReady,
  output logic         Halted,
  output logic         Done,
  output logic [15:0]  InstCount,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t       state;
  logic [A-1:0] pc;
  logic         handshake;
  logic         capture;

  // Handshake: InstOut/InstPC are accepted on any cycle with InstValid and
  // InstReady both high; while InstValid is high and InstReady low the
  // presented instruction and the PC hold.
  always_comb begin
    handshake = InstValid & InstReady;
    capture   = 1'b0;
    if (state == S_RUN && !BranchEn && (!InstValid || handshake))
      capture = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      InstOut   <= '0;
      InstPC    <= '0;
      InstValid <= 1'b0;
      Halted    <= 1'b0;
      Done      <= 1'b0;
      InstCount <= 16'd0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (Start) begin
            pc        <= StartAddr;
            InstValid <= 1'b0;
            InstCount <= 16'd0;
            Halted    <= 1'b0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (BranchEn) begin
            pc        <= BranchTarget;
            InstValid <= 1'b0;
          end else if (capture) begin
            InstOut   <= InstIn;
            InstPC    <= pc;
            InstValid <= 1'b1;
            pc        <= pc + A'(1);
            if (handshake)
              InstCount <= InstCount + 16'd1;
            if (InstIn == HALT_WORD)
              state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Only the halt word can be valid here; its acceptance ends the program.
          if (BranchEn) begin
            pc        <= BranchTarget;
            InstValid <= 1'b0;
            state     <= S_RUN;
          end else if (handshake) begin
            InstValid <= 1'b0;
            InstCount <= InstCount + 16'd1;
            Halted    <= 1'b1;
            Done      <= 1'b1;
            state     <= S_HALT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign InstAddress = pc;
  assign dbg_state   = state;

endmodule
